// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared constants, ID/result types and operand slice helper for pipe_arb_ctrl
package pipe_arb_pkg;
    localparam int LAT      = 3;
    localparam int N_DEF    = 10;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    typedef logic [IDW_DEF-1:0] id_t;
    typedef struct packed {
        id_t              id;
        logic [N_DEF-1:0] res;
    } res_t;
    function automatic logic [N_DEF-1:0] op_slice(input logic [NREQ_DEF*N_DEF-1:0] bus, input id_t i);
        return bus[i*N_DEF +: N_DEF];
    endfunction
endpackage

// File: rtl/pipe_arb_if.sv
// pipe_arb_if: requester/result bundle between the engines and pipe_arb_ctrl
interface pipe_arb_if
    import pipe_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_bus;
    logic [NREQ*N-1:0] b_bus;
    logic [NREQ*N-1:0] c_bus;
    logic [NREQ*N-1:0] d_bus;
    logic              stall;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [N-1:0]      res;
    logic              busy;
    modport master (output req, a_bus, b_bus, c_bus, d_bus, stall,
                    input  gnt, res_valid, res_id, res, busy);
    modport slave  (input  req, a_bus, b_bus, c_bus, d_bus, stall,
                    output gnt, res_valid, res_id, res, busy);
endinterface

// File: rtl/pipe_arb_dp.sv
// pipe_arb_dp: 3-stage ((A+B)+(C-D))*D datapath with valid/ID sideband and stall enable
module pipe_arb_dp #(
    parameter int N   = 10,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_v,
    input  logic [IDW-1:0] i_id,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic [N-1:0]   i_c,
    input  logic [N-1:0]   i_d,
    output logic           o_valid,
    output logic [IDW-1:0] o_id,
    output logic [N-1:0]   o_res,
    output logic           o_busy
);
    logic           r_v1, r_v2, r_v3;
    logic [N-1:0]   r_x1, r_x2, r_d1, r_x3, r_d2, r_res;
    logic [IDW-1:0] r_id1, r_id2, r_id3;
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_v1, r_v2, r_v3} <= '0;
            {r_x1, r_x2, r_d1, r_x3, r_d2, r_res} <= '0;
            {r_id1, r_id2, r_id3} <= '0;
        end else if (i_en) begin
            r_v1  <= i_v;
            r_x1  <= i_a + i_b;
            r_x2  <= i_c - i_d;
            r_d1  <= i_d;
            r_id1 <= i_id;
            r_v2  <= r_v1;
            r_x3  <= r_x1 + r_x2;
            r_d2  <= r_d1;
            r_id2 <= r_id1;
            r_v3  <= r_v2;
            // bubbles leave the last result visible
            if (r_v2) begin
                r_res <= r_x3 * r_d2;
                r_id3 <= r_id2;
            end
        end
    end
    assign o_valid = r_v3;
    assign o_id    = r_id3;
    assign o_res   = r_res;
    assign o_busy  = r_v1 | r_v2 | r_v3;
endmodule

// File: rtl/pipe_arb_ctrl.sv
// pipe_arb_ctrl: round-robin arbiter sharing pipe_arb_dp; PIPE_ARB_FIXED_PRIO_EN selects fixed priority
module pipe_arb_ctrl
    import pipe_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic      clk,
    input  logic      rst,
    pipe_arb_if.slave bus
);
    logic [IDW-1:0] w_win;
    logic           w_found;
    logic           w_fire;
    logic [N-1:0]   w_a, w_b, w_c, w_d;
`ifdef PIPE_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                w_found = 1'b1;
                w_win   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] r_rr_ptr;
    // scan downward so the requester nearest after r_rr_ptr is written last
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) r_rr_ptr <= IDW'(NREQ - 1);
        else if (w_fire) r_rr_ptr <= w_win;
    end
`endif
    assign w_fire  = w_found & ~bus.stall;
    assign bus.gnt = w_fire ? NREQ'(1) << w_win : '0;
    assign w_a = bus.a_bus[w_win*N +: N];
    assign w_b = bus.b_bus[w_win*N +: N];
    assign w_c = bus.c_bus[w_win*N +: N];
    assign w_d = bus.d_bus[w_win*N +: N];
    pipe_arb_dp #(.N(N), .IDW(IDW)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .i_en    (~bus.stall),
        .i_v     (w_fire),
        .i_id    (w_win),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_c     (w_c),
        .i_d     (w_d),
        .o_valid (bus.res_valid),
        .o_id    (bus.res_id),
        .o_res   (bus.res),
        .o_busy  (bus.busy)
    );
endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// tb_pipe_arb_ctrl: directed + random scoreboard bench for pipe_arb_ctrl (honours PIPE_ARB_FIXED_PRIO_EN)
module tb_pipe_arb_ctrl;
    import pipe_arb_pkg::*;
    localparam int N    = N_DEF;
    localparam int NREQ = NREQ_DEF;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pipe_arb_if #(.N(N), .NREQ(NREQ)) bus ();
    pipe_arb_ctrl #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [N-1:0] opa [NREQ];
    logic [N-1:0] opb [NREQ];
    logic [N-1:0] opc [NREQ];
    logic [N-1:0] opd [NREQ];
    res_t         sb [$];
    int           ptr = NREQ - 1;
    logic [2:0]   mv = '0;
    logic [N-1:0] last_res = '0;
    id_t          last_id = '0;
    int           n_chk = 0;
    int           n_fail = 0;
    function automatic logic [N-1:0] f(input logic [N-1:0] a, b, c, d);
        logic [N-1:0] x1, x2, x3;
        x1 = a + b;
        x2 = c - d;
        x3 = x1 + x2;
        return x3 * d;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic set_ops(input int i, input logic [N-1:0] a, b, c, d);
        opa[i] = a; opb[i] = b; opc[i] = c; opd[i] = d;
        bus.a_bus[i*N +: N] = a;
        bus.b_bus[i*N +: N] = b;
        bus.c_bus[i*N +: N] = c;
        bus.d_bus[i*N +: N] = d;
    endtask
    task automatic cycle();
        logic [NREQ-1:0] g;
        int w;
        res_t e;
        @(negedge clk);
        g = '0;
        w = 0;
        if (!bus.stall && !rst) begin
`ifdef PIPE_ARB_FIXED_PRIO_EN
            for (int k = NREQ - 1; k >= 0; k--)
                if (bus.req[k]) begin w = k; g = '0; g[k] = 1'b1; end
`else
            for (int k = NREQ; k >= 1; k--)
                if (bus.req[(ptr + k) % NREQ]) begin w = (ptr + k) % NREQ; g = '0; g[w] = 1'b1; end
`endif
        end
        if (!rst) begin
            chk("gnt", 32'(bus.gnt), 32'(g));
            chk("res_valid", 32'(bus.res_valid), 32'(mv[2]));
            chk("busy", 32'(bus.busy), 32'(|mv));
            if (mv[2] && sb.size() > 0) begin
                e = sb[0];
                chk("res_id", 32'(bus.res_id), 32'(e.id));
                chk("res", 32'(bus.res), 32'(e.res));
                if (!bus.stall) begin
                    void'(sb.pop_front());
                    last_res = e.res;
                    last_id  = e.id;
                end
            end else begin
                chk("res_hold", 32'(bus.res), 32'(last_res));
                chk("res_id_hold", 32'(bus.res_id), 32'(last_id));
            end
            if (|g) sb.push_back('{id: id_t'(w), res: f(opa[w], opb[w], opc[w], opd[w])});
        end
        @(posedge clk);
        if (rst) begin
            mv = '0;
            sb.delete();
            ptr = NREQ - 1;
            last_res = '0;
            last_id = '0;
        end else if (!bus.stall) begin
            mv = {mv[1:0], |g};
            if (|g) ptr = w;
        end
        #1;
    endtask
    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.stall = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, '0, '0, '0, '0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        // single op: 3+4 + 10-2 = 15, *2 = 30 on requester 0
        set_ops(0, 10'd3, 10'd4, 10'd10, 10'd2);
        bus.req = 4'b0001;
        cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        // all requesters held: rotating grants, back-to-back results
        for (int i = 0; i < NREQ; i++) set_ops(i, N'(10 * i + 1), N'(i + 2), N'(50 - i), N'(i + 3));
        bus.req = 4'b1111;
        repeat (8) cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        // modular wrap cases: 80 and 1021
        set_ops(1, 10'd1000, 10'd100, 10'd5, 10'd1);
        set_ops(2, 10'd1, 10'd1, 10'd0, 10'd3);
        bus.req = 4'b0110;
        repeat (2) cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        // stall with three ops in flight
        bus.req = 4'b1111;
        repeat (3) cycle();
        bus.stall = 1'b1;
        repeat (2) cycle();
        bus.stall = 1'b0;
        repeat (3) cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        // reset aborts in-flight ops and rewinds the pointer
        bus.req = 4'b1111;
        repeat (3) cycle();
        bus.req = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        bus.req = 4'b1111;
        cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        // held 0110: alternates in round-robin, requester 1 only in fixed priority
        bus.req = 4'b0110;
        repeat (4) cycle();
        bus.req = '0;
        repeat (LAT + 1) cycle();
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++)
                set_ops(i, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
            bus.req = NREQ'($urandom);
            bus.stall = ($urandom_range(0, 3) == 0);
            cycle();
        end
        bus.req = '0;
        bus.stall = 1'b0;
        repeat (LAT + 1) cycle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
